// File: rtl/panel_serializer_pkg.sv
// Shared types for the panel serializer: FSM state encoding and shift-command codes.
package panel_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_LSB  = 2'b01;
    localparam logic [1:0] S_MSB  = 2'b10;

endpackage

// File: rtl/panel_serializer_rate_divider.sv
// Bit-rate divider: counts 0..limit while enabled, tick flags the terminal count.
module rate_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic [DIV_W-1:0] limit,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Saturates at limit so the counter can never wrap within a wait period.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != limit) begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = (cnt == limit);

endmodule

// File: rtl/panel_serializer.sv
// Streams a latched frame into an external panel shift register: one clear load,
// then WIDTH shift strobes paced by a programmable divider.
module panel_serializer
    import panel_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] frame,
    input  logic             dir,
    input  logic [DIV_W-1:0] rate,
    output logic [WIDTH-1:0] d,
    output logic             load,
    output logic [1:0]       s,
    output logic             m_sig,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic [DIV_W-1:0] rate_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             div_clear;
    logic             div_tick;

    assign div_clear = (state != ST_WAIT);

    rate_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk   (clk),
        .clr   (clr),
        .clear (div_clear),
        .limit (rate_q),
        .tick  (div_tick)
    );

    // Single-process FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            dir_q   <= 1'b0;
            rate_q  <= '0;
            bit_cnt <= '0;
            d       <= '0;
            load    <= 1'b0;
            s       <= S_HOLD;
            m_sig   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            d     <= '0;
            load  <= 1'b0;
            s     <= S_HOLD;
            m_sig <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            shreg   <= frame;
                            dir_q   <= dir;
                            rate_q  <= rate;
                            bit_cnt <= '0;
                            state   <= ST_LOAD;
                            load    <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (div_tick) begin
                            state <= ST_SHIFT;
                            s     <= dir_q ? S_LSB : S_MSB;
                            m_sig <= dir_q ? shreg[0] : shreg[WIDTH-1];
                        end
                    end
                    ST_SHIFT: begin
                        // Move the next bit into the output position for the following strobe.
                        shreg   <= dir_q ? (shreg >> 1) : (shreg << 1);
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_panel_serializer.sv
// Self-checking bench for panel_serializer: vector table of transfers plus
// hand-written abort / reset / start-with-abort sequences.
module tb_panel_serializer;
    import panel_serializer_pkg::*;

    localparam int unsigned WIDTH = 28;
    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] frame;
    logic             dir;
    logic [DIV_W-1:0] rate;
    logic [WIDTH-1:0] d;
    logic             load;
    logic [1:0]       s;
    logic             m_sig;
    logic             busy;
    logic             done;

    panel_serializer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .abort (abort),
        .frame (frame),
        .dir   (dir),
        .rate  (rate),
        .d     (d),
        .load  (load),
        .s     (s),
        .m_sig (m_sig),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] frame;
        logic             dir;
        logic [DIV_W-1:0] rate;
        int               lat;
        bit               mutate;
    } vec_t;

    typedef struct {
        logic       bit_v;
        logic [1:0] cmd;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[5];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_load"}, 32'(load), 0);
        check({tag, "_s"}, 32'(s), 32'(S_HOLD));
        check({tag, "_msig"}, 32'(m_sig), 0);
        check({tag, "_d"}, 32'(d), 0);
    endtask

    task automatic push_expected(input logic [WIDTH-1:0] f, input logic dr);
        exp_t e;
        sbq.delete();
        for (int k = 0; k < int'(WIDTH); k++) begin
            e.bit_v = dr ? f[k] : f[WIDTH-1-k];
            e.cmd   = dr ? S_LSB : S_MSB;
            sbq.push_back(e);
        end
    endtask

    // Runs one transfer starting at cycle 0; abort_at / clr_at cut it short on that strobe number.
    task automatic run(input vec_t v, input int abort_at, input int clr_at);
        int   strobes;
        bit   fin;
        exp_t e;
        int   spacing;
        strobes = 0;
        fin     = 0;
        spacing = int'(v.rate) + 2;
        push_expected(v.frame, v.dir);
        frame = v.frame;
        dir   = v.dir;
        rate  = v.rate;
        start = 1'b1;
        for (int cyc = 1; cyc <= v.lat + 20 && !fin; cyc++) begin
            step();
            if (cyc == 1) begin
                start = 1'b0;
                check("load_cycle1", 32'(load), 1);
                check("busy_cycle1", 32'(busy), 1);
                check("d_on_load", 32'(d), 0);
            end else if (load) begin
                check("load_extra", 32'(cyc), 1);
            end
            if (v.mutate && !done) begin
                start = 1'($urandom_range(0, 1));
                frame = WIDTH'($urandom);
                dir   = 1'($urandom_range(0, 1));
                rate  = DIV_W'($urandom_range(0, 6));
            end
            if (s != S_HOLD) begin
                if (sbq.size() == 0) begin
                    check("strobe_overflow", 32'(strobes + 1), WIDTH);
                end else begin
                    e = sbq.pop_front();
                    check("m_sig", 32'(m_sig), 32'(e.bit_v));
                    check("s_cmd", 32'(s), 32'(e.cmd));
                    check("strobe_cycle", 32'(cyc), 32'(1 + (strobes + 1) * spacing));
                end
                strobes++;
                if (strobes == abort_at) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    check_quiet("abort");
                    for (int j = 0; j < 3 * spacing; j++) begin
                        step();
                        if (busy || done) check("abort_stays_idle", {30'd0, busy, done}, 0);
                    end
                    fin = 1;
                end else if (strobes == clr_at) begin
                    clr = 1'b0;
                    step();
                    clr = 1'b1;
                    check_quiet("clr");
                    for (int j = 0; j < 3 * spacing; j++) begin
                        step();
                        if (busy || done || load) check("clr_stays_idle", {29'd0, busy, done, load}, 0);
                    end
                    fin = 1;
                end
            end else if (m_sig) begin
                check("m_sig_outside_shift", 32'(m_sig), 0);
            end
            if (!fin && done) begin
                start = 1'b0;
                check("done_cycle", 32'(cyc), 32'(v.lat));
                check("strobe_count", 32'(strobes), WIDTH);
                check("busy_at_done", 32'(busy), 1);
                step();
                check("done_width", 32'(done), 0);
                check("busy_after_done", 32'(busy), 0);
                for (int j = 0; j < 3; j++) begin
                    step();
                    if (done || busy) check("no_second_done", {30'd0, busy, done}, 0);
                end
                fin = 1;
            end
        end
        if (!fin) check("transfer_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        vec_t va;
        vecs[0] = '{frame: 28'hA5A5A5A, dir: 1'b0, rate: 16'd0, lat: 58,  mutate: 1'b0};
        vecs[1] = '{frame: 28'h0000001, dir: 1'b1, rate: 16'd3, lat: 142, mutate: 1'b0};
        vecs[2] = '{frame: 28'h8000001, dir: 1'b0, rate: 16'd1, lat: 86,  mutate: 1'b0};
        vecs[3] = '{frame: 28'hFFFFFFF, dir: 1'b1, rate: 16'd0, lat: 58,  mutate: 1'b0};
        vecs[4] = '{frame: 28'h5A3C96F, dir: 1'b0, rate: 16'd2, lat: 114, mutate: 1'b1};

        clr   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frame = '0;
        dir   = 1'b0;
        rate  = '0;
        step();
        step();
        check_quiet("reset");
        clr = 1'b1;
        step();

        // start together with abort must not launch a transfer
        frame = 28'h1234567;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_quiet("start_abort");
        for (int j = 0; j < 4; j++) begin
            step();
            if (busy || load) check("start_abort_idle", {30'd0, busy, load}, 0);
        end

        for (int i = 0; i < 5; i++) begin
            run(vecs[i], 0, 0);
        end

        run(vecs[0], 10, 0);
        run(vecs[0], 0, 0);

        va = vecs[2];
        run(va, 0, 12);
        run(vecs[1], 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/panel_serializer.md
PANEL_SERIALIZER -- requirements
Module: panel_serializer

Interface
REQ-001 Parameter WIDTH, default 28, frame width in bits (panel register width).
REQ-002 Parameter DIV_W, default 16, width of the bit-rate divider.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to transmit the frame; sampled only in IDLE.
REQ-006 abort  input  1  terminates any transfer.
REQ-007 frame  input  WIDTH  parallel pattern to stream.
REQ-008 dir  input  1  0 = MSB first, 1 = LSB first.
REQ-009 rate  input  DIV_W  idle cycles between shift strobes.
REQ-010 d  output  WIDTH  parallel data for the panel register load.
REQ-011 load  output  1  one-cycle load strobe to the panel register.
REQ-012 s  output  2  shift command to the panel register: 00 hold, 10 MSB-first shift, 01 LSB-first shift.
REQ-013 m_sig  output  1  serial bit accompanying each shift strobe.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WAIT, SHIFT and DONE.
REQ-017 IDLE: on start=1 and abort=0, the block SHALL latch frame, dir and rate into internal registers and go to LOAD.
REQ-018 LOAD: the block SHALL assert load=1 and drive d with a zero word for exactly one cycle, then go to WAIT.
REQ-019 WAIT: the divider SHALL count 0..rate_latched and go to SHIFT on the cycle after reaching rate_latched; rate=0 SHALL give one shift strobe every 2 cycles (WAIT and SHIFT alternating).
REQ-020 SHIFT: the block SHALL drive s (10 if dir=0, 01 if dir=1) and m_sig = the next frame bit for exactly one cycle, then increment bit_cnt.
REQ-021 Bit order: with dir=0, bit k (k = 0..WIDTH-1) SHALL be frame[WIDTH-1-k]; with dir=1, bit k SHALL be frame[k].
REQ-022 After the WIDTH-th SHIFT the FSM SHALL go to DONE; otherwise it SHALL return to WAIT with the divider cleared.
REQ-023 DONE: the block SHALL assert done=1 for one cycle, then go to IDLE.
REQ-024 Outside SHIFT, s SHALL be 00 and m_sig SHALL be 0; outside LOAD, load SHALL be 0.
REQ-025 A change on start, frame, dir or rate while busy=1 SHALL have no effect on the transfer in progress.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge with no done pulse; abort takes priority over start and over the DONE transition.
REQ-027 bit_cnt SHALL be ceil(log2(WIDTH+1)) bits wide; the divider SHALL be DIV_W bits wide; neither counter SHALL wrap during a transfer.
REQ-028 Total latency from start to done SHALL be 2 + WIDTH*(rate+2) cycles.

Reset
REQ-029 On clr=0 at a rising edge: state=IDLE; busy, done, load and m_sig = 0; s=00; d, bit_cnt, divider and the latched registers = 0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer without a done pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the s command constants (S_HOLD=00, S_LSB=01, S_MSB=10).
REQ-032 The divider SHALL be a separate sub-module rate_divider (inputs: clk, clr, clear, limit; output: tick).

Verification
REQ-033 frame=28'hA5A5A5A, dir=0, rate=0 -> load pulse at cycle 1; 28 strobes with s=10; m_sig sequence 1,0,1,0,0,1,0,1,...; done at cycle 58.
REQ-034 frame=28'h0000001, dir=1, rate=3 -> first strobe carries m_sig=1, remaining 27 strobes carry m_sig=0; strobes spaced 5 cycles apart; done at cycle 142.
REQ-035 abort raised on the 10th strobe -> IDLE next cycle, s=00, busy=0, no done pulse; a following start then runs a full transfer.
REQ-036 start toggled and frame changed while busy -> transmitted bits match the originally latched frame; exactly one done pulse.
REQ-037 clr=0 held for 1 cycle mid-SHIFT -> all outputs take their reset values on the next edge; block stays in IDLE until a new start.
REQ-038 start=1 and abort=1 together in IDLE -> no transfer, busy stays 0.
